// File: rtl/taylor_pkg.sv
// Shared types and constant helpers for the Taylor-series exponential engine.
// Controller states, the fixed-point unity constant and the 1/k coefficient
// generator used to build the coefficient ROM.
package taylor_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_X = 3'd1,
        MUL_C = 3'd2,
        ACC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Unity in Q.FRAC is represented as 2^FRAC - 1 so it fits in FRAC bits.
    function automatic logic [63:0] one_const(input int frac);
        return (64'd1 << frac) - 64'd1;
    endfunction

    // Series coefficient c_k = floor(ONE / k); k = 0 maps to ONE.
    function automatic logic [63:0] coef(input int k, input int frac);
        logic [63:0] one;
        one = one_const(frac);
        if (k == 0) begin
            return one;
        end
        return one / 64'(k);
    endfunction

endpackage

// File: rtl/taylor_coef_lut.sv
// Combinational coefficient ROM: index k in, c_k = floor(ONE / k) out.
// Contents are elaborated from taylor_pkg::coef so they track FRAC and TERMS.
module taylor_coef_lut
    import taylor_pkg::*;
#(
    parameter int TERMS = 8,
    parameter int FRAC  = 8,
    parameter int WIDTH = 16
) (
    input  logic [$clog2(TERMS)-1:0] k_i,
    output logic [WIDTH-1:0]         c_o
);

    localparam int KW = $clog2(TERMS);

    logic [WIDTH-1:0] rom [TERMS];

    for (genvar i = 0; i < TERMS; i++) begin : g_rom
        localparam logic [63:0] C_I = coef(i, FRAC);
        assign rom[i] = C_I[WIDTH-1:0];
    end

    // Select the coefficient for the current term index.
    always_comb begin
        c_o = '0;
        for (int i = 0; i < TERMS; i++) begin
            if (k_i == KW'(i)) begin
                c_o = rom[i];
            end
        end
    end

endmodule

// File: rtl/taylor_series_engine.sv
// Sequential Taylor-series evaluator for e^x / e^-x on unsigned Q.FRAC data.
// One shared multiplier alternates between the operand X and the coefficient
// c_k; each term takes three cycles (MUL_X, MUL_C, ACC).
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; done pulses for one cycle when result is valid, and result is
// held until the next accept.
// Optional macro TAYLOR_SAT_EN: saturating product/add and clamped subtract;
// without it all arithmetic wraps modulo 2^WIDTH.
module taylor_series_engine
    import taylor_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int TERMS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             gt,
    output state_t           dbg_state
);

    localparam int KW = $clog2(TERMS);
    localparam logic [63:0]      ONE_L  = one_const(FRAC);
    localparam logic [WIDTH-1:0] ONE    = ONE_L[WIDTH-1:0];
    localparam logic [KW-1:0]    K_LAST = KW'(TERMS - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] x_q, m_q, t_q;
    logic [KW-1:0]    k_q;
    logic             mode_q;

    logic [WIDTH-1:0]   coef_k;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   prod_w;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   acc_add, acc_sub;
    logic               unused_arith;

    taylor_coef_lut #(
        .TERMS (TERMS),
        .FRAC  (FRAC),
        .WIDTH (WIDTH)
    ) u_coef_lut (
        .k_i (k_q),
        .c_o (coef_k)
    );

    // Shared multiplier: operand X in MUL_X, coefficient c_k otherwise.
    assign mul_b  = (state_q == MUL_X) ? x_q : coef_k;
    assign prod   = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, mul_b};
    assign sum_w  = {1'b0, t_q} + {1'b0, m_q};
    assign diff_w = {1'b0, t_q} - {1'b0, m_q};

`ifdef TAYLOR_SAT_EN
    assign prod_w  = (|prod[2*WIDTH-1:FRAC+WIDTH]) ? '1 : prod[FRAC +: WIDTH];
    assign acc_add = sum_w[WIDTH]  ? '1 : sum_w[WIDTH-1:0];
    assign acc_sub = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
`else
    assign prod_w  = prod[FRAC +: WIDTH];
    assign acc_add = sum_w[WIDTH-1:0];
    assign acc_sub = diff_w[WIDTH-1:0];
`endif

    // Bits outside the kept windows are intentionally dropped.
    assign unused_arith = ^{prod, sum_w, diff_w};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: three cycles per term, one DONE cycle at the end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL_X;
            MUL_X:   state_d = MUL_C;
            MUL_C:   state_d = ACC;
            ACC:     state_d = (k_q == K_LAST) ? DONE : MUL_X;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        ready     = (state_q == IDLE);
        done      = (state_q == DONE);
        dbg_state = state_q;
    end

    // Datapath: capture on accept, multiply twice per term, then accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            m_q    <= '0;
            t_q    <= '0;
            k_q    <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q    <= in_x;
                        m_q    <= ONE;
                        t_q    <= ONE;
                        k_q    <= KW'(1);
                        mode_q <= mode;
                    end
                end
                MUL_X, MUL_C: begin
                    m_q <= prod_w;
                end
                ACC: begin
                    // Odd terms are subtracted for e^-x.
                    t_q <= (mode_q && k_q[0]) ? acc_sub : acc_add;
                    if (k_q != K_LAST) begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = t_q;
    assign gt     = (t_q > in_y);

endmodule

// File: tb/tb_taylor_series_engine.sv
// Scoreboard bench for taylor_series_engine at default parameters.
// Expected results come from a plain-arithmetic series model; a monitor pops
// and compares on every done pulse, including accept-to-done latency.
module tb_taylor_series_engine;
  import taylor_pkg::*;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int TERMS = 8;
  localparam int LAT   = 3 * (TERMS - 1);
  localparam longint MAXV = 65535;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             gt;
  state_t           dbg_state;

  taylor_series_engine #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .TERMS (TERMS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_x      (in_x),
    .in_y      (in_y),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .gt        (gt),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  int               errors = 0;
  int               checks = 0;
  int               done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // reference model: sum of x^k/k! terms in Q.FRAC
  function automatic longint mulq(input longint a, input longint b);
    longint p;
    p = (a * b) >> FRAC;
`ifdef TAYLOR_SAT_EN
    if (p > MAXV) p = MAXV;
`else
    p = p & MAXV;
`endif
    return p;
  endfunction

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x, input logic m);
    longint one, term, acc;
    one  = (64'd1 << FRAC) - 1;
    term = one;
    acc  = one;
    for (int k = 1; k < TERMS; k++) begin
      term = mulq(term, longint'(x));
      term = mulq(term, one / k);
      if (m && (k % 2 == 1)) begin
`ifdef TAYLOR_SAT_EN
        acc = (term > acc) ? 0 : acc - term;
`else
        acc = (acc - term) & MAXV;
`endif
      end else begin
`ifdef TAYLOR_SAT_EN
        acc = (acc + term > MAXV) ? MAXV : acc + term;
`else
        acc = (acc + term) & MAXV;
`endif
      end
    end
    return WIDTH'(acc);
  endfunction

  // monitor: compare every done pulse against the head of the queue
  logic [WIDTH-1:0] mon_exp;
  int               mon_acc;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        check("result", 64'(result), 64'(mon_exp));
        check("gt", 64'(gt), 64'(mon_exp > in_y));
        check("latency", 64'(cyc - mon_acc), 64'(LAT));
      end
    end
  end

  // driver: wait for ready, issue one request, record expectation
  task automatic do_op(input logic [WIDTH-1:0] x, input logic m, input logic [WIDTH-1:0] y);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1) begin
      n++;
      if (n > 100) begin
        fail_now("ready_timeout");
        return;
      end
      @(negedge clk);
    end
    in_x  = x;
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_y  = y;
    exp_q.push_back(model(x, m));
    acc_q.push_back(cyc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  // watchdog
  initial begin
    #500000;
    fail_now("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  int dc0;
  logic [WIDTH-1:0] rx;
  logic             rm;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    in_x  = '0;
    in_y  = '0;
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'h0);
    check("rst_gt", 64'(gt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // zero operand
    do_op(16'h0000, 1'b0, 16'h0000);
    drain();
    check("zero_result", 64'(result), 64'h00FF);

    // e^1 and threshold compare on both sides of the result
    do_op(16'h0100, 1'b0, 16'h02AE);
    drain();
    check("e1_result", 64'(result), 64'h02AF);
    check("e1_gt_below", 64'(gt), 64'd1);
    in_y = 16'h02AF;
    #1;
    check("e1_gt_equal", 64'(gt), 64'd0);

    // e^-1
    do_op(16'h0100, 1'b1, 16'h0000);
    drain();
    check("em1_result", 64'(result), 64'h005F);

    // start held high: accepts at edge 0 and at edge 3*(TERMS-1)+2 only
    @(negedge clk);
    dc0   = done_cnt;
    in_x  = 16'h0100;
    mode  = 1'b0;
    in_y  = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(16'h0100, 1'b0));
    acc_q.push_back(cyc);
    repeat (10) @(posedge clk);
    #1;
    in_x = 16'h0080;
    mode = 1'b1;
    repeat (LAT + 2 - 10) @(posedge clk);
    #1;
    exp_q.push_back(model(16'h0080, 1'b1));
    acc_q.push_back(cyc);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    check("held_start_done_count", 64'(done_cnt - dc0), 64'd2);

    // reset in the middle of a computation
    do_op(16'h0100, 1'b0, 16'h0000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'h0);
    check("midrst_gt", 64'(gt), 64'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0100, 1'b0, 16'h02AE);
    drain();
    check("post_rst_result", 64'(result), 64'h02AF);

    // large operand: saturates with the macro, wraps without
    do_op(16'h0800, 1'b0, 16'h1234);
    drain();
`ifdef TAYLOR_SAT_EN
    check("sat_result", 64'(result), 64'hFFFF);
    check("sat_gt", 64'(gt), 64'd1);
`else
    check("wrap_not_saturated", 64'(result != 16'hFFFF), 64'd1);
`endif

    // randomized back-to-back traffic
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) rx = WIDTH'($urandom_range(0, 16'h0300));
      else rx = WIDTH'($urandom_range(0, 16'hFFFF));
      rm = 1'($urandom_range(0, 1));
      do_op(rx, rm, WIDTH'($urandom_range(0, 16'hFFFF)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taylor_series_engine.md
# taylor_series_engine

- Parametrised Taylor-series evaluator. Computes e^x (mode 0) or e^-x (mode 1) on an unsigned fixed-point input and compares the result against a threshold.
- Generalises the team's 16-bit / 8-term exponential datapath:
  - width, fraction bits and term count are parameters;
  - sign mode is selectable per operation;
  - the controller FSM and a start/ready/done handshake are integrated.
- Sits between the input-capture stage and the threshold-decision logic.

## Interface
Parameters:
- WIDTH, 16, datapath and result width (unsigned, Q(WIDTH-FRAC).FRAC)
- FRAC, 8, fractional bits; unity constant ONE = 2^FRAC − 1
- TERMS, 8, series terms including term 0 (≥2); counter width $clog2(TERMS)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; accepted only when ready=1
- mode  in  1  0: all terms added (e^x); 1: odd terms subtracted (e^-x); sampled on accept
- in_x  in  WIDTH  operand; sampled on accept
- in_y  in  WIDTH  threshold, compared live (not sampled)
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  accumulator T; held until next accept
- gt  out  1  combinational: result > in_y (unsigned, full width)

## Operation
- Registers:
  - X (operand), M (current term), T (accumulator), k (term index), mode_q.
- Coefficient ROM: c_k = floor(ONE / k) for k = 1..TERMS−1.
- Product rule: p = (a·b) >> FRAC, keeping the low WIDTH bits of the 2·WIDTH product.
- FSM states: IDLE, MUL_X, MUL_C, ACC, DONE.
  - IDLE: on start: X←in_x, M←ONE, T←ONE, k←1, mode_q←mode; go to MUL_X.
  - MUL_X: M←(M·X)>>FRAC; go to MUL_C.
  - MUL_C: M←(M·c_k)>>FRAC; go to ACC.
  - ACC: update T, then branch on k.
    - T←T+M when mode_q=0 or k even.
    - T←T−M when mode_q=1 and k odd.
    - If k=TERMS−1 go to DONE; else k←k+1 and go to MUL_X.
  - DONE: done=1; go to IDLE.
- Without the configuration macro, overflow in add, subtract or product wraps modulo 2^WIDTH.
- Boundary behaviour:
  - start while busy (ready=0): ignored, no queueing.
  - start asserted in DONE: ignored; accepted in the next IDLE cycle.
  - in_x, mode changes mid-operation: no effect.
  - in_x=0: result = ONE.
- Reset, including mid-operation:
  - all registers cleared; state IDLE;
  - ready=1, done=0, result=0, gt = (0 > in_y) = 0;
  - any in-flight computation is discarded.

## Timing
- Accept at edge 0 (start & ready).
- Each term takes 3 cycles.
- The final ACC executes at edge 3·(TERMS−1); done is high for the following cycle.
- Latency from accept edge to done high: 3·(TERMS−1) cycles (21 at defaults).
- Back-to-back throughput: one operation per 3·(TERMS−1)+2 cycles.
- ready is low from the cycle after accept through DONE.
- result and gt are stable and valid while done=1 and in the following IDLE cycles.

## Configuration
- Macro: TAYLOR_SAT_EN. Defined: saturating arithmetic.
  - Product saturates to 2^WIDTH−1 if any bit above the WIDTH-bit window is set.
  - Add saturates to 2^WIDTH−1.
  - Subtract clamps at 0.
- Undefined: modulo-2^WIDTH wrap everywhere, no extra logic.

## Structure
- Package taylor_pkg holds:
  - the state enum (IDLE, MUL_X, MUL_C, ACC, DONE);
  - function one_const(FRAC);
  - function coef(k, FRAC) used to build the ROM.
- One sub-module: taylor_coef_lut (parameters TERMS, FRAC, WIDTH), with index k in and c_k out, combinational.
- FSM, datapath registers and shared multiplier live in the top module. A single multiplier is muxed between X and c_k.

## Test plan
All scenarios use defaults (WIDTH=16, FRAC=8, TERMS=8).
- Reset: rst pulsed mid-computation (cycle 10 after accept) → ready=1, done=0, result=0x0000 immediately; new start then completes normally.
- Zero operand: in_x=0x0000, mode=0 → done 21 cycles after accept, result=0x00FF.
- e^1: in_x=0x0100, mode=0 → result=0x02AF (687); in_y=0x02AE gives gt=1, in_y=0x02AF gives gt=0.
- e^-1: in_x=0x0100, mode=1 → result=0x005F (95).
- Handshake: start held high through a run → exactly one done pulse per accept; a second operation is accepted on the IDLE cycle after DONE; in_x changed mid-run does not alter the result.
- Saturation: in_x=0x0800, mode=0, TAYLOR_SAT_EN defined → result=0xFFFF, gt=1 for in_y=0x1234; without the macro the result differs from 0xFFFF.
